// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Multi-cycle control FSM for an RV32 subset (R-type, lw, sw, beq) driving a
// shared-ALU / single-memory datapath through fetch, decode, execute, memory
// and writeback. Memory accesses use a request/ready handshake guarded by a
// timeout watchdog.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   - an unrecognised opcode in DECODE parks the FSM in TRAP with
//               illegal_instr=1 until reset.
//   undefined - an unrecognised opcode executes as a NOP (back to FETCH);
//               illegal_instr is tied 0.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles waited on mem_ready before ERROR (0 = no watchdog)
//   TO_W            wait counter width, must hold TIMEOUT_CYCLES
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   opcode          IR[6:0], valid from DECODE onward
//   zero            ALU zero flag used by beq
//   mem_ready       memory completes the current access this cycle
//   mem_req/mem_we  memory request / write strobe
//   iord            memory address select: 0=PC, 1=ALUOut
//   ir_write        load IR (combinational: FETCH and mem_ready)
//   pc_write        load PC (combinational: fetch completion or taken beq)
//   pc_src          PC source: 0=ALU result, 1=ALUOut
//   alu_src_a/b     ALU operand selects
//   alu_op          00=add, 01=sub, 10=decode funct
//   reg_write       register file write enable
//   mem_to_reg      writeback source: 0=ALUOut, 1=MDR
//   bus_error       sticky memory-timeout flag
//   illegal_instr   illegal opcode trap flag

module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TO_W           = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       bus_error,
    output logic       illegal_instr
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_ERROR, S_TRAP
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_ERROR
    } state_t;
`endif

    // Moore control word, registered so every output is glitch-free and is
    // cleared by the asynchronous reset the moment rst_n falls.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       bus_error;
`ifdef ILLEGAL_TRAP_EN
        logic       illegal_instr;
`endif
    } ctrl_t;

    state_t          state;
    state_t          nxt;
    ctrl_t           ctrl_q;
    logic [TO_W-1:0] wait_cnt;
    logic            timed_out;

    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;   // branch target precomputed into ALUOut
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_WB_R: begin
                c.reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.iord    = 1'b1;
            end
            S_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.pc_src    = 1'b1;
            end
            S_ERROR: begin
                c.bus_error = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                c.illegal_instr = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    // The watchdog fires only when the limit is reached and memory is still
    // not ready; a ready in the same cycle completes the access instead.
    assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LIMIT) && !mem_ready;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      nxt = S_DECODE;
                else if (timed_out) nxt = S_ERROR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:         nxt = S_EXEC_R;
                    OP_LW, OP_SW: nxt = S_MEM_ADDR;
                    OP_BEQ:       nxt = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    default:      nxt = S_TRAP;
`else
                    default:      nxt = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R:   nxt = S_WB_R;
            S_WB_R:     nxt = S_FETCH;
            S_MEM_ADDR: nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)      nxt = S_WB_MEM;
                else if (timed_out) nxt = S_ERROR;
            end
            S_MEM_WR: begin
                if (mem_ready)      nxt = S_FETCH;
                else if (timed_out) nxt = S_ERROR;
            end
            S_WB_MEM:   nxt = S_FETCH;
            S_BRANCH:   nxt = S_FETCH;
            S_ERROR:    nxt = S_ERROR;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     nxt = S_TRAP;
`endif
            default:    nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ctrl_q   <= '0;
            wait_cnt <= '0;
        end else begin
            state  <= nxt;
            ctrl_q <= moore_ctrl(nxt);
            // Any state change (including wait state to wait state) restarts
            // the count; it saturates so a disabled watchdog never wraps.
            if (nxt != state)
                wait_cnt <= '0;
            else if (is_wait(state) && !mem_ready && (wait_cnt != '1))
                wait_cnt <= wait_cnt + TO_W'(1);
        end
    end

    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign iord       = ctrl_q.iord;
    assign pc_src     = ctrl_q.pc_src;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign reg_write  = ctrl_q.reg_write;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign bus_error  = ctrl_q.bus_error;

    // Mealy strobes: fetch completion loads IR and PC+4; a taken beq loads
    // the branch target held in ALUOut.
    assign ir_write = (state == S_FETCH) && mem_ready;
    assign pc_write = ir_write || ((state == S_BRANCH) && zero);

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = ctrl_q.illegal_instr;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a per-cycle vector table
// {mem_ready, opcode, zero, expected outputs} for the instruction flows,
// followed by hand-written watchdog and mid-access reset sequences.
// Output vector bit order:
//   [14] mem_req [13] mem_we [12] iord [11] ir_write [10] pc_write
//   [9] pc_src [8] alu_src_a [7:6] alu_src_b [5:4] alu_op
//   [3] reg_write [2] mem_to_reg [1] bus_error [0] illegal_instr

module tb_multicycle_controller;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // Expected output words per state, derived by hand from the state table.
    localparam logic [14:0] E_IDLE   = 15'b000_00_0_0_00_00_0_0_0_0;
    localparam logic [14:0] E_FWAIT  = 15'b100_00_0_0_01_00_0_0_0_0;
    localparam logic [14:0] E_FRDY   = 15'b100_11_0_0_01_00_0_0_0_0;
    localparam logic [14:0] E_DEC    = 15'b000_00_0_0_11_00_0_0_0_0;
    localparam logic [14:0] E_EXEC   = 15'b000_00_0_1_00_10_0_0_0_0;
    localparam logic [14:0] E_WBR    = 15'b000_00_0_0_00_00_1_0_0_0;
    localparam logic [14:0] E_MADDR  = 15'b000_00_0_1_10_00_0_0_0_0;
    localparam logic [14:0] E_MRD    = 15'b101_00_0_0_00_00_0_0_0_0;
    localparam logic [14:0] E_MWR    = 15'b111_00_0_0_00_00_0_0_0_0;
    localparam logic [14:0] E_WBM    = 15'b000_00_0_0_00_00_1_1_0_0;
    localparam logic [14:0] E_BRT    = 15'b000_01_1_1_00_01_0_0_0_0;
    localparam logic [14:0] E_BRNT   = 15'b000_00_1_1_00_01_0_0_0_0;
    localparam logic [14:0] E_ERR    = 15'b000_00_0_0_00_00_0_0_1_0;
    localparam logic [14:0] E_TRAP   = 15'b000_00_0_0_00_00_0_0_0_1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_write, mem_to_reg, bus_error, illegal_instr;
    logic [14:0] act;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rdy;
        logic [6:0]  op;
        logic        z;
        logic [14:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT_CYCLES(15), .TO_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .bus_error     (bus_error),
        .illegal_instr (illegal_instr)
    );

    assign act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alu_op, reg_write, mem_to_reg, bus_error, illegal_instr};

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
        end
    endtask

    task automatic add(input logic rdy, input logic [6:0] op, input logic z,
                       input logic [14:0] exp, input string name);
        vec_t v;
        v.rdy = rdy; v.op = op; v.z = z; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    // Entered just after a rising edge: drive, sample on the falling edge,
    // then return just after the next rising edge.
    task automatic cycle(input logic rdy, input logic [6:0] op, input logic z,
                         input logic [14:0] exp, input string name);
        mem_ready = rdy;
        opcode    = op;
        zero      = z;
        @(negedge clk);
        check(name, act, exp);
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in IDLE for the cycle following the return.
    task automatic do_reset(input string name);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b1;
        opcode    = OP_R;
        repeat (2) @(posedge clk);
        #1;
        check(name, act, E_IDLE);
        rst_n = 1'b1;
    endtask

    initial begin
        // R-type, zero-wait; mem_ready/zero asserted where they must be ignored
        add(1, OP_R,   1, E_IDLE,  "r_idle");
        add(1, OP_R,   0, E_FRDY,  "r_fetch");
        add(1, OP_R,   1, E_DEC,   "r_decode");
        add(1, OP_R,   1, E_EXEC,  "r_exec");
        add(1, OP_R,   1, E_WBR,   "r_wb");
        // lw with three wait cycles in MEM_RD
        add(1, OP_LW,  0, E_FRDY,  "lw_fetch");
        add(1, OP_LW,  0, E_DEC,   "lw_decode");
        add(1, OP_LW,  0, E_MADDR, "lw_addr");
        add(0, OP_LW,  0, E_MRD,   "lw_rd_w1");
        add(0, OP_LW,  0, E_MRD,   "lw_rd_w2");
        add(0, OP_LW,  0, E_MRD,   "lw_rd_w3");
        add(1, OP_LW,  0, E_MRD,   "lw_rd_done");
        add(1, OP_LW,  0, E_WBM,   "lw_wb");
        // sw zero-wait
        add(1, OP_SW,  0, E_FRDY,  "sw_fetch");
        add(1, OP_SW,  0, E_DEC,   "sw_decode");
        add(1, OP_SW,  0, E_MADDR, "sw_addr");
        add(1, OP_SW,  0, E_MWR,   "sw_wr");
        // beq taken then not taken
        add(1, OP_BEQ, 0, E_FRDY,  "beq1_fetch");
        add(1, OP_BEQ, 0, E_DEC,   "beq1_decode");
        add(1, OP_BEQ, 1, E_BRT,   "beq1_taken");
        add(1, OP_BEQ, 1, E_FRDY,  "beq2_fetch");
        add(1, OP_BEQ, 1, E_DEC,   "beq2_decode");
        add(1, OP_BEQ, 0, E_BRNT,  "beq2_not_taken");
        // illegal opcode
        add(1, OP_BAD, 0, E_FRDY,  "bad_fetch");
        add(1, OP_BAD, 0, E_DEC,   "bad_decode");
`ifdef ILLEGAL_TRAP_EN
        add(1, OP_BAD, 1, E_TRAP,  "bad_trap1");
        add(0, OP_R,   1, E_TRAP,  "bad_trap2");
        add(1, OP_LW,  0, E_TRAP,  "bad_trap3");
`else
        add(0, OP_BAD, 0, E_FWAIT, "bad_nop_fetch_wait");
        add(1, OP_R,   0, E_FRDY,  "bad_nop_fetch");
        add(1, OP_R,   0, E_DEC,   "bad_nop_decode");
`endif

        do_reset("reset_state");
        foreach (tbl[i]) cycle(tbl[i].rdy, tbl[i].op, tbl[i].z, tbl[i].exp, tbl[i].name);

        // Watchdog: 16 FETCH cycles without ready (count reaches 15), then ERROR
        do_reset("reset_before_timeout");
        cycle(1, OP_R, 0, E_IDLE, "to_idle");
        for (int i = 0; i < 16; i++) cycle(0, OP_R, 0, E_FWAIT, "to_fetch_wait");
        cycle(1, OP_R, 0, E_ERR, "to_error");
        for (int i = 0; i < 3; i++) cycle(1, OP_R, 1, E_ERR, "to_error_sticky");

        // Ready arriving on the limit cycle completes the fetch normally
        do_reset("reset_before_limit");
        cycle(1, OP_R, 0, E_IDLE, "lim_idle");
        for (int i = 0; i < 15; i++) cycle(0, OP_R, 0, E_FWAIT, "lim_fetch_wait");
        cycle(1, OP_R, 0, E_FRDY, "lim_fetch_done");
        cycle(1, OP_R, 0, E_DEC,  "lim_decode");
        cycle(1, OP_R, 0, E_EXEC, "lim_exec");

        // Asynchronous reset in the middle of a MEM_RD wait
        do_reset("reset_before_midrd");
        cycle(1, OP_LW, 0, E_IDLE,  "mid_idle");
        cycle(1, OP_LW, 0, E_FRDY,  "mid_fetch");
        cycle(1, OP_LW, 0, E_DEC,   "mid_decode");
        cycle(1, OP_LW, 0, E_MADDR, "mid_addr");
        cycle(0, OP_LW, 0, E_MRD,   "mid_rd_wait");
        #2;
        check("mid_rd_still_req", act, E_MRD);
        rst_n = 1'b0;
        #1;
        check("mid_rd_async_drop", act, E_IDLE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, OP_R, 0, E_IDLE, "mid_after_idle");
        cycle(1, OP_R, 0, E_FRDY, "mid_after_fetch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle sequencer for the RV32 core subset (R-type, lw, sw, beq). Replaces per-instruction combinational control with an FSM that steps a shared-ALU / single-memory datapath through fetch, decode, execute, memory and writeback. Stalls on a ready/request memory handshake, with a timeout watchdog. Sits between the instruction register's opcode field and the datapath mux/enable controls.

Parameters:
TIMEOUT_CYCLES, 15, max cycles waiting on mem_ready before entering ERROR; 0 disables the watchdog.
TO_W, 4, width of wait counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0], valid from DECODE onward
zero  in  1  ALU zero flag (beq compare result)
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  1=write, 0=read; valid only with mem_req
iord  out  1  memory address: 0=PC, 1=ALUOut
ir_write  out  1  load IR from memory data
pc_write  out  1  load PC
pc_src  out  1  PC source: 0=ALU result, 1=ALUOut
alu_src_a  out  1  0=PC, 1=rs1
alu_src_b  out  2  00=rs2, 01=const 4, 10=imm, 11=branch offset
alu_op  out  2  00=add, 01=sub, 10=decode funct
reg_write  out  1  register file write enable
mem_to_reg  out  1  writeback source: 0=ALUOut, 1=MDR
bus_error  out  1  sticky memory-timeout flag
illegal_instr  out  1  see Optional Feature; tied 0 when feature off

Behaviour:
- Reset (rst_n low, async): state=IDLE, wait counter=0, bus_error=0; all outputs 0.
- Outputs are Moore (decoded from state) except where noted; every output not listed for a state is 0.
- IDLE: outputs 0; next cycle -> FETCH.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. ir_write=pc_write=mem_ready (Mealy), pc_src=0. On mem_ready -> DECODE, else stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next by opcode: 0110011 -> EXEC_R; 0000011 or 0100011 -> MEM_ADDR; 1100011 -> BRANCH; other -> FETCH (NOP) or TRAP (see Optional Feature).
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> WB_R.
- WB_R: reg_write=1, mem_to_reg=0 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Load -> MEM_RD; store -> MEM_WR.
- MEM_RD: mem_req=1, mem_we=0, iord=1; on mem_ready -> WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, iord=1; on mem_ready -> FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero (Mealy) -> FETCH.
- Latency with zero-wait memory: R=4, lw=5, sw=4, beq=3 cycles. Each wait cycle adds 1.
- Handshake:
  - mem_req held continuously from entry to a wait state (FETCH/MEM_RD/MEM_WR) until the cycle mem_ready is sampled 1.
  - mem_ready in any other state is ignored.
  - Address and mem_we are stable while mem_req is held.
- Watchdog:
  - Counter clears on entry to a wait state and increments each cycle mem_ready=0.
  - If the counter equals TIMEOUT_CYCLES with mem_ready=0, go to ERROR.
  - mem_ready=1 in the same cycle the count hits the limit wins, and the access completes normally.
- ERROR: all outputs 0 except bus_error=1. Sticky; exits only via rst_n.
- Reset mid-access drops mem_req immediately (async) and returns to IDLE.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: unrecognised opcode in DECODE -> TRAP. TRAP holds illegal_instr=1, with all other outputs 0, until rst_n. PC already points past the faulting word.
- Undefined: unrecognised opcode -> FETCH (executes as NOP). illegal_instr is tied 0 and there is no TRAP state.

Test Plan:
- Release reset, mem_ready=1 always, R-type opcode 0110011 -> states IDLE,FETCH,DECODE,EXEC_R,WB_R,FETCH; reg_write=1 exactly in cycle 4 after FETCH entry; pc_write/ir_write pulse once.
- lw (0000011) with mem_ready delayed 3 cycles in MEM_RD -> mem_req=1, iord=1 held for 4 cycles; WB_MEM asserts reg_write=1, mem_to_reg=1; total 8 cycles.
- sw (0100011), zero-wait -> mem_we=1 with mem_req for one cycle; reg_write never asserted.
- beq (1100011), zero=1 then zero=0 on a second beq -> pc_write=1, pc_src=1 in BRANCH for the first; pc_write=0 for the second.
- TIMEOUT_CYCLES=15, mem_ready held 0 in FETCH -> ERROR after 15 wait cycles, bus_error=1 sticky; also mem_ready=1 on cycle 15 completes the access normally.
- Opcode 1111111: with ILLEGAL_TRAP_EN -> illegal_instr=1, FSM frozen. Without it -> back to FETCH, illegal_instr=0. Assert rst_n=0 mid-MEM_RD -> mem_req=0 immediately.
